reg_file_rd: RTL and testbench
==============================

# reg_file_rd

Parametrised register file with one write port and two registered read ports, generalising the datapath's 16-to-1 register select into a self-contained storage-plus-select block. It holds the CPU's general-purpose registers and feeds the ALU operand latches. Reads are captured into output registers with write-to-read bypass, so the ALU sees the same-cycle write result. A read-enable holds operands during stalls.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 16, number of registers (2..256, need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; do not override)
- ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe
- wr_addr  input  AW  write register index
- wr_data  input  WIDTH  write data
- rd_en  input  1  capture new operands this cycle; 0 = hold
- rd_a_addr  input  AW  operand A register index
- rd_b_addr  input  AW  operand B register index
- rd_a_data  output  WIDTH  registered operand A
- rd_b_data  output  WIDTH  registered operand B
- rd_valid  output  1  high the cycle after a capture, low otherwise

## Operation
- Storage: DEPTH x WIDTH flops, all cleared to 0 by reset.
- Write: on rising clk with wr_en=1 and wr_addr < DEPTH, reg[wr_addr] <= wr_data.
- Writes with wr_addr >= DEPTH are dropped, with no side effects.
- ZERO_R0=1: writes to index 0 are dropped.
- Read select per port: the combinational value sel_x is chosen in this priority order:
  - 0 if addr >= DEPTH;
  - 0 if ZERO_R0=1 and addr=0;
  - wr_data if wr_en=1 and wr_addr=addr (bypass);
  - otherwise reg[addr].
- Capture: on rising clk with rd_en=1, rd_a_data <= sel_a, rd_b_data <= sel_b, rd_valid <= 1.
- Hold: with rd_en=0, rd_a_data and rd_b_data keep their value and rd_valid <= 0.
  - Writes still occur during hold.
  - Held outputs are not refreshed by a write to the held address.
- Both ports may address the same register; both then return identical data, including the bypass case.
- Bypass never applies to a dropped write (out of range, or index 0 with ZERO_R0=1).
- No internal state machine beyond the storage and output registers; the block is fully pipelined with one capture per cycle.

## Timing
- Reset: asynchronous assert, sampled deassert.
  - While rst_n=0: all registers, rd_a_data and rd_b_data are 0, and rd_valid is 0.
  - First capture is possible on the first rising edge with rst_n=1.
- Read latency: 1 cycle. Address and rd_en are presented in cycle N; data and rd_valid are visible in cycle N+1.
- Write latency: 1 cycle to storage.
  - A read of the same address in the same cycle returns the new data via bypass.
  - A read in a later cycle returns it from storage.
- Back-to-back captures: rd_valid stays high continuously while rd_en=1.
- Reset asserted mid-stream: outputs clear immediately, regardless of clk.
  - A capture or write in flight on that edge is lost.
- Critical path: address decode -> DEPTH:1 select -> bypass mux -> output flop. No combinational path from inputs to outputs.

## Test plan
- Reset then read: assert rst_n=0 mid-cycle with outputs nonzero.
  - Required: outputs go to 0 asynchronously.
  - Then release reset, rd_en=1, rd_a_addr=5, rd_b_addr=15 -> next cycle rd_a_data=0, rd_b_data=0, rd_valid=1.
- Write-then-read, all indices: write k*0x1111 to reg k for k=0..15 on consecutive cycles, then read each pair (k, 15-k).
  - Required: values match with 1-cycle latency and rd_valid=1 every cycle.
- Bypass: in one cycle, wr_en=1, wr_addr=7, wr_data=0xBEEF, rd_a_addr=7, rd_b_addr=7, rd_en=1.
  - Required: next cycle both outputs = 0xBEEF.
  - A read of reg 7 one cycle later still returns 0xBEEF.
- Hold: capture reg 3 = 0x1234, then set rd_en=0 for 3 cycles while writing 0x5678 to reg 3.
  - Required: rd_a_data stays 0x1234 and rd_valid=0 for those cycles.
  - Setting rd_en=1 again yields 0x5678.
- ZERO_R0=1: write 0xFFFF to reg 0 with a simultaneous read of reg 0.
  - Required: read returns 0 on that cycle and on all later cycles.
- DEPTH=12 (AW=4): write 0xAAAA to address 13, then read addresses 13 and 11.
  - Required: address 13 reads 0 (including same-cycle bypass), reg 11 is unchanged, and no other register is corrupted.

Source files
------------

// File: rtl/reg_file_rd.sv
// rtl/reg_file_rd.sv - register file with one write port and two registered, bypassed read ports
//
// Parameters:
//   WIDTH    data width of each register
//   DEPTH    number of registers (2..256, need not be a power of two)
//   AW       address width, derived from DEPTH (leave at default)
//   ZERO_R0  1 = register 0 reads as zero and ignores writes
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      write strobe
//   wr_addr    write register index
//   wr_data    write data
//   rd_en      capture new operands this cycle; 0 = hold previous operands
//   rd_a_addr  operand A register index
//   rd_b_addr  operand B register index
//   rd_a_data  registered operand A
//   rd_b_data  registered operand B
//   rd_valid   high the cycle after a capture, low otherwise

module reg_file_rd #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             rd_valid
);

    logic [WIDTH-1:0] regs [DEPTH];

    // Effective write: strobe present, index inside the array, and not the
    // hard-wired zero register. Both storage update and bypass key off this,
    // so a dropped write can never leak onto a read port.
    logic wr_ok;

    always_comb begin
        wr_ok = wr_en && (32'(wr_addr) < DEPTH);
        if ((ZERO_R0 != 0) && (wr_addr == '0)) begin
            wr_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            // Compare against each index instead of indexing directly so a
            // non-power-of-two DEPTH never produces an out-of-range access.
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == AW'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Operand select for both read ports, in priority order:
    // out-of-range -> zero register -> same-cycle write bypass -> storage.
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] sel     [2];

    assign rd_addr[0] = rd_a_addr;
    assign rd_addr[1] = rd_b_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            sel[p] = '0;
            if (32'(rd_addr[p]) >= DEPTH) begin
                sel[p] = '0;
            end else if ((ZERO_R0 != 0) && (rd_addr[p] == '0)) begin
                sel[p] = '0;
            end else if (wr_ok && (wr_addr == rd_addr[p])) begin
                sel[p] = wr_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_addr[p] == AW'(i)) begin
                        sel[p] = regs[i];
                    end
                end
            end
        end
    end

    // Operand registers: load on rd_en, otherwise hold so a stalled ALU keeps
    // its operands even if the source register is rewritten meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_data <= '0;
            rd_b_data <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_a_data <= sel[0];
                rd_b_data <= sel[1];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rd.sv
// tb/tb_reg_file_rd.sv - scoreboard bench for reg_file_rd (default, ZERO_R0=1 and DEPTH=12 instances)

module tb_reg_file_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en     [3];
    logic [3:0]  wr_addr   [3];
    logic [15:0] wr_data   [3];
    logic        rd_en     [3];
    logic [3:0]  rd_a_addr [3];
    logic [3:0]  rd_b_addr [3];
    logic [15:0] rd_a_data [3];
    logic [15:0] rd_b_data [3];
    logic        rd_valid  [3];

    always #5 clk = ~clk;

    reg_file_rd #(.WIDTH(16), .DEPTH(16), .ZERO_R0(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_a_addr(rd_a_addr[0]), .rd_b_addr(rd_b_addr[0]),
        .rd_a_data(rd_a_data[0]), .rd_b_data(rd_b_data[0]), .rd_valid(rd_valid[0])
    );

    reg_file_rd #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_a_addr(rd_a_addr[1]), .rd_b_addr(rd_b_addr[1]),
        .rd_a_data(rd_a_data[1]), .rd_b_data(rd_b_data[1]), .rd_valid(rd_valid[1])
    );

    reg_file_rd #(.WIDTH(16), .DEPTH(12), .ZERO_R0(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
        .rd_en(rd_en[2]), .rd_a_addr(rd_a_addr[2]), .rd_b_addr(rd_b_addr[2]),
        .rd_a_data(rd_a_data[2]), .rd_b_data(rd_b_data[2]), .rd_valid(rd_valid[2])
    );

    typedef struct {
        int          d;
        logic [15:0] a;
        logic [15:0] b;
        logic        v;
    } exp_t;

    exp_t        sbq [$];
    logic [15:0] mm [3][16];
    logic [15:0] oa [3];
    logic [15:0] ob [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int dep(int d);
        return (d == 2) ? 12 : 16;
    endfunction

    function automatic bit zr(int d);
        return (d == 1);
    endfunction

    function automatic bit wr_eff(int d);
        if (!wr_en[d]) return 1'b0;
        if (int'(wr_addr[d]) >= dep(d)) return 1'b0;
        if (zr(d) && wr_addr[d] == 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] msel(int d, logic [3:0] a);
        if (int'(a) >= dep(d)) return 16'h0000;
        if (zr(d) && a == 4'd0) return 16'h0000;
        if (wr_eff(d) && wr_addr[d] == a) return wr_data[d];
        return mm[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            oa[d] = 16'h0;
            ob[d] = 16'h0;
            for (int i = 0; i < 16; i++) mm[d][i] = 16'h0;
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            wr_en[d]     = 1'b0;
            wr_addr[d]   = 4'd0;
            wr_data[d]   = 16'h0;
            rd_en[d]     = 1'b0;
            rd_a_addr[d] = 4'd0;
            rd_b_addr[d] = 4'd0;
        end
    endtask

    task automatic set_wr(int d, logic [3:0] a, logic [15:0] v);
        wr_en[d]   = 1'b1;
        wr_addr[d] = a;
        wr_data[d] = v;
    endtask

    task automatic set_rd(int d, logic [3:0] a, logic [3:0] b);
        rd_en[d]     = 1'b1;
        rd_a_addr[d] = a;
        rd_b_addr[d] = b;
    endtask

    task automatic chk(string tag, int d, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_a"}, d, rd_a_data[d], 16'h0);
            chk({tag, "_b"}, d, rd_b_data[d], 16'h0);
            chk({tag, "_v"}, d, 16'(rd_valid[d]), 16'h0);
        end
    endtask

    // One clock: push expected outputs from the current stimulus, clock,
    // commit model writes, then pop and compare against the DUT outputs.
    task automatic step(string tag);
        exp_t        e;
        bit          do_w [3];
        logic [3:0]  wa   [3];
        logic [15:0] wd   [3];
        for (int d = 0; d < 3; d++) begin
            if (rd_en[d]) begin
                oa[d] = msel(d, rd_a_addr[d]);
                ob[d] = msel(d, rd_b_addr[d]);
            end
            e.d = d;
            e.a = oa[d];
            e.b = ob[d];
            e.v = rd_en[d];
            sbq.push_back(e);
            do_w[d] = wr_eff(d);
            wa[d]   = wr_addr[d];
            wd[d]   = wr_data[d];
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (do_w[d]) mm[d][wa[d]] = wd[d];
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            e = sbq.pop_front();
            chk({tag, "_a"}, e.d, rd_a_data[e.d], e.a);
            chk({tag, "_b"}, e.d, rd_b_data[e.d], e.b);
            chk({tag, "_v"}, e.d, 16'(rd_valid[e.d]), 16'(e.v));
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_zero("por");
        repeat (2) @(posedge clk);
        #1 chk_zero("por_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // first capture right after reset release
        set_rd(0, 4'd5, 4'd15);
        step("first_rd");

        // write all indices then read pairs (k, 15-k) back to back
        for (int k = 0; k < 16; k++) begin
            set_wr(0, 4'(k), 16'(k * 16'h1111));
            step("fill");
        end
        for (int k = 0; k < 16; k++) begin
            set_rd(0, 4'(k), 4'(15 - k));
            step("pair_rd");
        end

        // same-cycle write bypass on both ports, then read from storage
        set_wr(0, 4'd7, 16'hBEEF);
        set_rd(0, 4'd7, 4'd7);
        step("bypass");
        set_rd(0, 4'd7, 4'd7);
        step("bypass_later");

        // hold: operands stay put while the source is rewritten
        set_wr(0, 4'd3, 16'h1234);
        step("hold_prep");
        set_rd(0, 4'd3, 4'd9);
        step("hold_cap");
        set_wr(0, 4'd3, 16'h5678);
        step("hold1");
        step("hold2");
        step("hold3");
        set_rd(0, 4'd3, 4'd3);
        step("hold_release");

        // ZERO_R0 instance
        set_wr(1, 4'd0, 16'hFFFF);
        set_rd(1, 4'd0, 4'd0);
        step("zr0_same");
        set_wr(1, 4'd1, 16'h4321);
        set_rd(1, 4'd0, 4'd1);
        step("zr0_bypass1");
        set_rd(1, 4'd0, 4'd1);
        step("zr0_later");

        // DEPTH=12 instance: out-of-range write dropped, no bypass
        for (int k = 0; k < 12; k++) begin
            set_wr(2, 4'(k), 16'(k * 16'h1111));
            step("d12_fill");
        end
        set_wr(2, 4'd13, 16'hAAAA);
        set_rd(2, 4'd13, 4'd11);
        step("d12_oor_same");
        set_rd(2, 4'd13, 4'd12);
        step("d12_oor_later");
        for (int k = 0; k < 12; k++) begin
            set_rd(2, 4'(k), 4'(11 - k));
            step("d12_pair");
        end

        // asynchronous reset in the middle of a read stream
        set_rd(0, 4'd5, 4'd15);
        step("pre_rst");
        set_rd(0, 4'd1, 4'd2);
        set_wr(0, 4'd4, 16'hCAFE);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 chk_zero("rst_edge_lost");
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        set_rd(0, 4'd5, 4'd4);
        step("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
